// File: rtl/i2c_master_rd.sv
// rtl/i2c_master_rd.sv - I2C master: write register pointer, repeated START, read one byte
// Optional feature macro: I2C_MASTER_RETRY_EN (retry an address NACK at ACK1 up to 3 times)
module i2c_master_rd #(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [6:0]  SLAVE_ADDR = 7'b1101101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] reg_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK1, REG, ACK2, RSTART, ADDR_R, ACK3, READ, MNACK, STOP
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       reg_q;
  logic [7:0]       rx_shift;
  logic [7:0]       tx_byte;
  logic             tx_bit;
  logic             nack_q;
  logic             sda_oe;
  logic             scl_c;
  logic             sda_oe_c;
  logic             tick;
  logic             sample;
  logic             slot_end;
  logic             byte_end;
  logic             scl_mid;
  logic             in_ack;
  logic             retry_take;
  logic             retry_pend;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign tick     = busy && (div_cnt == DIV_LAST);
  assign sample   = tick && (phase == 2'd2);
  assign slot_end = tick && (phase == 2'd3);
  assign byte_end = slot_end && (bit_cnt == 3'd7);
  assign scl_mid  = (phase == 2'd1) || (phase == 2'd2);
  assign in_ack   = (state == ACK1) || (state == ACK2) || (state == ACK3);

`ifdef I2C_MASTER_RETRY_EN
  logic [1:0] retry_cnt;

  // An address NACK is retried until three retries have been spent.
  assign retry_take = slot_end && (state == ACK1) && nack_q && (retry_cnt != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt  <= 2'd0;
      retry_pend <= 1'b0;
    end else if ((state == IDLE) && start) begin
      retry_cnt  <= 2'd0;
      retry_pend <= 1'b0;
    end else if (retry_take) begin
      retry_cnt  <= retry_cnt + 2'd1;
      retry_pend <= 1'b1;
    end else if (slot_end && (state == STOP)) begin
      retry_pend <= 1'b0;
    end
  end
`else
  assign retry_take = 1'b0;
  assign retry_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl_c      = 1'b1;
    sda_oe_c   = 1'b0;
    case (state)
      ADDR_W:  tx_byte = {SLAVE_ADDR, 1'b0};
      ADDR_R:  tx_byte = {SLAVE_ADDR, 1'b1};
      default: tx_byte = reg_q;
    endcase
    tx_bit = tx_byte[~bit_cnt];

    unique case (state)
      IDLE: begin
        if (start) state_next = START;
      end
      START: begin
        // sda falls at q2 while scl is still high
        scl_c    = (phase != 2'd3);
        sda_oe_c = phase[1];
        if (slot_end) state_next = ADDR_W;
      end
      ADDR_W: begin
        scl_c    = scl_mid;
        sda_oe_c = ~tx_bit;
        if (byte_end) state_next = ACK1;
      end
      ACK1: begin
        scl_c = scl_mid;
        if (slot_end) state_next = nack_q ? STOP : REG;
      end
      REG: begin
        scl_c    = scl_mid;
        sda_oe_c = ~tx_bit;
        if (byte_end) state_next = ACK2;
      end
      ACK2: begin
        scl_c = scl_mid;
        if (slot_end) state_next = nack_q ? STOP : RSTART;
      end
      RSTART: begin
        scl_c    = scl_mid;
        sda_oe_c = phase[1];
        if (slot_end) state_next = ADDR_R;
      end
      ADDR_R: begin
        scl_c    = scl_mid;
        sda_oe_c = ~tx_bit;
        if (byte_end) state_next = ACK3;
      end
      ACK3: begin
        scl_c = scl_mid;
        if (slot_end) state_next = nack_q ? STOP : READ;
      end
      READ: begin
        scl_c = scl_mid;
        if (byte_end) state_next = MNACK;
      end
      MNACK: begin
        scl_c = scl_mid;
        if (slot_end) state_next = STOP;
      end
      STOP: begin
        // sda held low through q1, released at q2 with scl high
        scl_c    = (phase != 2'd0);
        sda_oe_c = ~phase[1];
        if (slot_end) state_next = retry_pend ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      div_cnt  <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      reg_q    <= 8'h00;
      rx_shift <= 8'h00;
      nack_q   <= 1'b0;
    end else begin
      done   <= 1'b0;
      scl    <= scl_c;
      sda_oe <= sda_oe_c;
      if (state == IDLE) begin
        if (start) begin
          busy    <= 1'b1;
          ack_err <= 1'b0;
          reg_q   <= reg_addr;
          div_cnt <= '0;
          phase   <= 2'd0;
          bit_cnt <= 3'd0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) phase <= phase + 2'd1;
        if (sample) begin
          nack_q <= sda;
          if (state == READ) rx_shift <= {rx_shift[6:0], sda};
        end
        if (slot_end) begin
          bit_cnt <= (state_next == state) ? bit_cnt + 3'd1 : 3'd0;
          if (state == MNACK) rd_data <= rx_shift;
          if (in_ack && nack_q && !retry_take) ack_err <= 1'b1;
          if ((state == STOP) && (state_next == IDLE)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/i2c_master_rd.md
# i2c_master_rd

Single-register I2C read master. It drives `scl` and open-drain `sda` toward the I2C slave register file. On a host `start` pulse it performs a combined transaction: write the register pointer, issue a repeated START, then read one data byte. The byte is returned on `rd_data` with a `done` pulse. It sits between the host-side control logic and the I2C bus.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period; legal values are 2 and above.
- `SLAVE_ADDR`, default 7'b1101101: 7-bit target address.
- `clk`  in  1  system clock. The block has one clock, and everything is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `reg_addr`  in  8  register pointer byte, captured when `start` is accepted.
- `rd_data`  out  8  last successfully read byte.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle completion pulse, for both success and error.
- `ack_err`  out  1  set when the slave NACKs; held until the next accepted `start`.
- `scl`  out  1  I2C clock, push-pull.
- `sda`  inout  1  I2C data, open-drain: the block drives only 0 or z.

## Operation
- **Reset values:** `scl`=1, `sda`=z, `busy`=0, `done`=0, `ack_err`=0, `rd_data`=8'h00, state=IDLE.
- **Tick timing:** a divider generates a one-cycle `tick` every `CLK_DIV` clocks. The divider runs only while `busy` is high and is reset on accept.
- **Bit slots:** each bit slot is 4 ticks (phases q0–q3).
  - q0: `scl`=0; `sda` changes.
  - q1: `scl` rises.
  - q2: `scl`=1; `sda` is sampled.
  - q3: `scl` falls.
- **START:** `sda` falls during q1–q2 while `scl`=1.
- **STOP:** `sda` held 0 at q0, released in q2 while `scl`=1.
- **States:** IDLE → START → ADDR_W → ACK1 → REG → ACK2 → RSTART → ADDR_R → ACK3 → READ → MNACK → STOP → IDLE.
- **Byte order and acknowledges:**
  - ADDR_W sends {SLAVE_ADDR,1'b0} MSB first.
  - ADDR_R sends {SLAVE_ADDR,1'b1}.
  - REG sends the captured `reg_addr` MSB first.
  - In ACKn the master releases `sda` and samples it at q2; 0 means ACK.
  - READ shifts 8 bits MSB first into a shift register.
  - MNACK releases `sda` for one slot (the master NACKs).
- **Bit counter:** 3-bit, reset at each byte state entry. The byte is complete when the counter wraps from 7.
- **Success:** `rd_data` loads the shift register on leaving MNACK.
- **NACK in any ACK state:** set `ack_err`, go directly to STOP, and leave `rd_data` unchanged.
- **`start` while busy:** ignored and not queued.
- **`reg_addr` changes after accept:** have no effect.
- **Reset mid-transaction:** all outputs return to reset values immediately. The bus is released with no STOP, and the slave is left to resynchronise.

## Timing
- **Accept:** `start`=1 in IDLE at edge N causes `busy`=1 and `ack_err`=0 at edge N+1.
- **Success duration:** START, 4×9 data/ack slots, RSTART and STOP make 39 slots = 156 ticks. `busy` stays high for exactly 156·`CLK_DIV` cycles.
- **Completion:** `done`=1 and `busy`=0 on the same edge, then `done` returns to 0 on the next edge. `rd_data` is valid from the `done` edge.
- **Error durations:**
  - NACK at ACK1 aborts after 11 slots (START + 9 + STOP) = 44·`CLK_DIV` cycles.
  - NACK at ACK2 aborts after 20 slots.
  - NACK at ACK3 aborts after 30 slots.
- **Back-to-back:** a new `start` is accepted earliest on the edge after `done`. Consecutive transactions are separated by at least 1 idle cycle.

## Configuration
- Macro `I2C_MASTER_RETRY_EN`.
- **Defined:** a NACK at ACK1 triggers STOP followed by a fresh START. The retry repeats up to 3 times before setting `ack_err`. `busy` stays high across retries, and `done` pulses once at the end. A retry counter (2-bit) resets on accept.
- **Undefined:** there is no retry. The first NACK sets `ack_err` and completes as described in Operation.

## Test plan
- **Normal read:** slave model at 7'b1101101 holding reg 8'h4A = 8'h1D; `start` with `reg_addr`=8'h4A, `CLK_DIV`=4.
  - Expected: the bus shows bytes 8'hDA, 8'h4A, 8'hDB with ACKs and master NACK.
  - Expected: `rd_data`=8'h1D, `ack_err`=0, `busy` high for 624 cycles, single `done` pulse.
- **Address NACK:** slave model at 7'b1010000, macro undefined.
  - Expected: `ack_err`=1 and STOP after ACK1; `busy` high for 176 cycles; `rd_data` keeps its prior value 8'h1D.
- **Bus-level checks:**
  - Expected: `sda` changes only while `scl`=0, except START (falls with `scl`=1) and STOP (rises with `scl`=1).
  - Expected: the block never drives `sda`=1.
- **`start` during busy:** pulse `start` with `reg_addr`=8'h00 mid-transaction.
  - Expected: ignored; the bus still carries 8'h4A; exactly one `done`.
- **Reset mid-transaction:** assert `rst_n`=0 during READ bit 3.
  - Expected: immediately `scl`=1, `sda`=z, `busy`=0, `done`=0, `rd_data`=8'h00.
  - Expected: a subsequent read returns 8'h1D.
- **Retry (`I2C_MASTER_RETRY_EN` defined):** slave NACKs the first 2 address bytes, then ACKs.
  - Expected: 3 STARTs before success, `rd_data`=8'h1D, `ack_err`=0.
  - With 4 NACKs expected: `ack_err`=1 and one `done` pulse.
